// File: rtl/mac_ctrl_pkg.sv
// Shared types for the MAC group sequencer: FSM state encoding and the
// helper that sizes the pipeline-drain counter from the MAC latency.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        OUT
    } state_t;

    // Bits needed to count 0..mac_lat inclusive.
    function automatic int drain_cnt_width(input int mac_lat);
        return (mac_lat < 1) ? 1 : $clog2(mac_lat + 1);
    endfunction

endpackage

// File: rtl/mac_ctrl.sv
// Job sequencer for a GROUP_NB-lane MAC group: clear, stream beats, drain, hand off.
// Optional MAC_CTRL_RELU_EN clamps negative lanes to zero at result capture.
module mac_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int GROUP_NB  = 4,
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int LEN_WIDTH = 12,
    parameter int MAC_LAT   = 6,
    localparam int RESULT_WIDTH = IMG_WIDTH + KER_WIDTH + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [LEN_WIDTH-1:0]             cfg_len,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [GROUP_NB*IMG_WIDTH-1:0]    str_img,
    input  logic [GROUP_NB*KER_WIDTH-1:0]    str_ker,
    input  logic                             str_valid,
    output logic                             str_ready,
    output logic                             mac_rst,
    output logic [GROUP_NB*IMG_WIDTH-1:0]    mac_img,
    output logic [GROUP_NB*KER_WIDTH-1:0]    mac_ker,
    output logic                             mac_val,
    input  logic [GROUP_NB*RESULT_WIDTH-1:0] mac_result,
    output logic [GROUP_NB*RESULT_WIDTH-1:0] out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
);

    localparam int WCW = drain_cnt_width(MAC_LAT);

    state_t                            state_q, state_d;
    logic [LEN_WIDTH-1:0]              len_q, len_d;
    logic [LEN_WIDTH-1:0]              beat_cnt_q, beat_cnt_d;
    logic [WCW-1:0]                    wait_cnt_q, wait_cnt_d;
    logic                              mac_rst_q, mac_rst_d;
    logic [GROUP_NB*IMG_WIDTH-1:0]     mac_img_q, mac_img_d;
    logic [GROUP_NB*KER_WIDTH-1:0]     mac_ker_q, mac_ker_d;
    logic                              mac_val_q, mac_val_d;
    logic [GROUP_NB*RESULT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                              out_valid_q, out_valid_d;
    logic [GROUP_NB*RESULT_WIDTH-1:0]  capture;
    logic [LEN_WIDTH-1:0]              beat_inc;

    genvar gi;
    generate
        for (gi = 0; gi < GROUP_NB; gi++) begin : g_lane
`ifdef MAC_CTRL_RELU_EN
            assign capture[gi*RESULT_WIDTH +: RESULT_WIDTH] =
                mac_result[gi*RESULT_WIDTH + RESULT_WIDTH - 1] ? '0
                                                               : mac_result[gi*RESULT_WIDTH +: RESULT_WIDTH];
`else
            assign capture[gi*RESULT_WIDTH +: RESULT_WIDTH] = mac_result[gi*RESULT_WIDTH +: RESULT_WIDTH];
`endif
        end
    endgenerate

    assign beat_inc = beat_cnt_q + LEN_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mac_img_d   = mac_img_q;
        mac_ker_d   = mac_ker_q;
        mac_val_d   = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    len_d      = cfg_len;
                    beat_cnt_d = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                wait_cnt_d = '0;
                state_d    = (len_q == '0) ? DRAIN : FEED;
            end
            FEED: begin
                if (str_valid) begin
                    mac_img_d  = str_img;
                    mac_ker_d  = str_ker;
                    mac_val_d  = 1'b1;
                    beat_cnt_d = beat_inc;
                    if (beat_inc == len_q) begin
                        wait_cnt_d = '0;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Capture lands MAC_LAT+1 cycles after the last operand beat.
                if (wait_cnt_q == WCW'(MAC_LAT)) begin
                    out_data_d  = capture;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        mac_rst_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            mac_rst_q   <= 1'b1;
            mac_img_q   <= '0;
            mac_ker_q   <= '0;
            mac_val_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mac_rst_q   <= mac_rst_d;
            mac_img_q   <= mac_img_d;
            mac_ker_q   <= mac_ker_d;
            mac_val_q   <= mac_val_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign str_ready = (state_q == FEED);
    assign busy      = (state_q != IDLE);
    assign mac_rst   = mac_rst_q;
    assign mac_img   = mac_img_q;
    assign mac_ker   = mac_ker_q;
    assign mac_val   = mac_val_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_ctrl.sv
// Directed bench for mac_ctrl with a behavioural 4-lane MAC group model.
module tb_mac_ctrl;

    localparam int GN      = 4;
    localparam int MAC_LAT = 6;
    localparam int RW      = 33;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [11:0]     cfg_len = '0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [63:0]     str_img = '0;
    logic [63:0]     str_ker = '0;
    logic            str_valid = 1'b0;
    logic            str_ready;
    logic            mac_rst;
    logic [63:0]     mac_img;
    logic [63:0]     mac_ker;
    logic            mac_val;
    logic [GN*RW-1:0] mac_result;
    logic [GN*RW-1:0] out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int rst_pulses = 0;
    logic mac_rst_prev = 1'b0;

    mac_ctrl #(.GROUP_NB(GN), .IMG_WIDTH(16), .KER_WIDTH(16), .LEN_WIDTH(12), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst(rst),
        .cfg_len(cfg_len), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .str_img(str_img), .str_ker(str_ker), .str_valid(str_valid), .str_ready(str_ready),
        .mac_rst(mac_rst), .mac_img(mac_img), .mac_ker(mac_ker), .mac_val(mac_val),
        .mac_result(mac_result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // MAC group model: accumulator plus a delay line so the sum settles MAC_LAT cycles after mac_val.
    logic [GN*RW-1:0] acc = '0;
    logic [GN*RW-1:0] pipe [0:MAC_LAT-2];

    function automatic logic [RW-1:0] prod(input logic [15:0] a, input logic [15:0] b);
        logic signed [RW-1:0] sa, sb;
        sa = {{(RW-16){a[15]}}, a};
        sb = {{(RW-16){b[15]}}, b};
        return sa * sb;
    endfunction

    always @(posedge clk) begin
        if (mac_rst) acc <= '0;
        else if (mac_val)
            for (int l = 0; l < GN; l++)
                acc[l*RW +: RW] <= acc[l*RW +: RW] + prod(mac_img[l*16 +: 16], mac_ker[l*16 +: 16]);
        pipe[0] <= acc;
        for (int k = 1; k < MAC_LAT-1; k++) pipe[k] <= pipe[k-1];
        mac_rst_prev <= mac_rst;
        if (mac_rst && !mac_rst_prev) rst_pulses <= rst_pulses + 1;
    end
    assign mac_result = pipe[MAC_LAT-2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic run_job(input string name, input logic [11:0] len, input logic [63:0] img,
                           input logic [63:0] ker, input bit gaps, input int hold,
                           input bit keep_cfg, input logic [GN*RW-1:0] exp);
        int beats, guard, n, sr_seen, p0;
        bit hs, stable;
        logic [GN*RW-1:0] snap;
        p0 = rst_pulses;
        cfg_len   = len;
        cfg_valid = 1'b1;
        tick();
        if (!keep_cfg) cfg_valid = 1'b0;
        check({name, "_clear"}, 256'(mac_rst), 256'(1));
        check({name, "_cfgrdy_lo"}, 256'(cfg_ready), 256'(0));
        tick();
        if (len != 0) begin
            check({name, "_strrdy"}, 256'(str_ready), 256'(1));
            beats = 0;
            guard = 0;
            while (beats < int'(len) && guard < 200) begin
                str_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                str_img   = img;
                str_ker   = ker;
                hs = str_valid && str_ready;
                tick();
                guard++;
                if (hs) begin
                    beats++;
                    if (beats == 1) check({name, "_macimg"}, 256'(mac_img), 256'(img));
                    check({name, "_macval"}, 256'(mac_val), 256'(1));
                end
            end
            str_valid = 1'b0;
            check({name, "_beats"}, 256'(beats), 256'(len));
        end
        // Ticks from the last beat (or from CLEAR->DRAIN when len=0) to out_valid.
        n = 0;
        sr_seen = 0;
        while (!out_valid && n < 100) begin
            if (str_ready) sr_seen++;
            tick();
            n++;
        end
        check({name, "_latency"}, 256'(n), 256'(MAC_LAT + 1));
        check({name, "_no_strrdy"}, 256'(sr_seen), 256'(0));
        check({name, "_data"}, 256'(out_data), 256'(exp));
        check({name, "_macrst_pulses"}, 256'(rst_pulses - p0), 256'(1));
        snap = out_data;
        stable = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (out_data !== snap || !out_valid || cfg_ready) stable = 1'b0;
        end
        if (hold > 0) check({name, "_hold_stable"}, 256'(stable), 256'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_outval_lo"}, 256'(out_valid), 256'(0));
        check({name, "_idle"}, 256'(busy), 256'(0));
        check({name, "_cfgrdy_hi"}, 256'(cfg_ready), 256'(1));
    endtask

    initial begin
        logic [GN*RW-1:0] exp5;
        // Reset held for three cycles.
        rst = 1'b0;
        tick(); tick(); tick();
        check("rst_cfg_ready", 256'(cfg_ready), 256'(1));
        check("rst_str_ready", 256'(str_ready), 256'(0));
        check("rst_mac_rst", 256'(mac_rst), 256'(1));
        check("rst_mac_val", 256'(mac_val), 256'(0));
        check("rst_mac_img", 256'(mac_img), 256'(0));
        check("rst_mac_ker", 256'(mac_ker), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        rst = 1'b1;
        check("rel_cfg_ready", 256'(cfg_ready), 256'(1));
        tick();
        check("rel_mac_rst_lo", 256'(mac_rst), 256'(0));

        // len=3, img 1..4, ker 2: lanes 6,12,18,24.
        run_job("len3", 12'd3, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd2}}, 1'b0, 0, 1'b0,
                {33'd24, 33'd18, 33'd12, 33'd6});
        // len=0: cleared accumulators.
        run_job("len0", 12'd0, {4{16'd9}}, {4{16'd9}}, 1'b0, 0, 1'b0, '0);
        // Random input gaps and 10 cycles of output backpressure.
        run_job("gaps", 12'd3, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd2}}, 1'b1, 10, 1'b0,
                {33'd24, 33'd18, 33'd12, 33'd6});

        // Abort a 5-beat job after 2 beats.
        cfg_len = 12'd5;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        str_valid = 1'b1;
        str_img = {4{16'd100}};
        str_ker = {4{16'd100}};
        tick(); tick();
        str_valid = 1'b0;
        check("abort_macval", 256'(mac_val), 256'(1));
        rst = 1'b0;
        #1;
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_mac_rst", 256'(mac_rst), 256'(1));
        check("abort_mac_val", 256'(mac_val), 256'(0));
        tick();
        rst = 1'b1;
        tick();
`ifdef MAC_CTRL_RELU_EN
        exp5 = '0;
`else
        exp5 = {4{33'h1_FFFF_FFF1}};
`endif
        run_job("neg15", 12'd1, {4{16'd5}}, {4{16'hFFFD}}, 1'b0, 0, 1'b0, exp5);

        // Back-to-back jobs with cfg_valid held high throughout.
        run_job("b2b_a", 12'd2, {16'd10, 16'd20, 16'd30, 16'd40}, {16'd1, 16'd2, 16'd3, 16'd4},
                1'b0, 3, 1'b1, {33'd20, 33'd80, 33'd180, 33'd320});
        run_job("b2b_b", 12'd1, {4{16'd7}}, {4{16'd7}}, 1'b0, 0, 1'b0, {4{33'd49}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
